// File: rtl/mem_pkg.sv
// ============================================================================
//  Package    : mem_pkg
//  Description: Shared widths and types for the on-chip RAM stream writer.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Default geometry of the on-chip scene/BVH RAM.
  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 10;

  // Writer sequencing states.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RUN  = 2'd1,
    WR_FIN  = 2'd2
  } wr_state_e;

  // One stream beat as seen by the writer.
  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
  } beat_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_stream_writer.sv
// ============================================================================
//  Module     : mem_stream_writer
//  Description: Accepts a valid/ready word stream and writes it to the on-chip
//               RAM at consecutive (wrapping) addresses starting at a
//               programmed base. Used to load RAM contents at runtime.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stream_writer
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_baseAddr,
  input  logic [ADDR_W:0]   io_len,
  input  logic              io_abort,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  output logic              io_wrEna,
  output logic [ADDR_W-1:0] io_wrAddr,
  output logic [DATA_W-1:0] io_wrData,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_aborted,
  output logic [ADDR_W:0]   io_wordCount
);

  // State encodings tied to the shared enum so both views stay in sync.
  localparam logic [1:0] ST_IDLE = WR_IDLE;
  localparam logic [1:0] ST_RUN  = WR_RUN;
  localparam logic [1:0] ST_FIN  = WR_FIN;

  localparam logic [ADDR_W:0] C_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] C_ZERO = '0;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic              r_abort_seen;
  logic              r_wr_ena;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_done;
  logic              r_aborted;

  logic [ADDR_W:0]   w_remaining;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_ready;
  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  beat_t             w_beat;

  // Handshake and address generation; abort masks ready so the beat offered
  // in the abort cycle is left with the producer.
  always_comb begin
    w_beat.data = io_in_data;
    w_remaining = r_len - r_count;
    w_count_inc = r_count + C_ONE;
    w_ready     = (r_state == ST_RUN) && (w_remaining != C_ZERO) && !io_abort;
    w_accept    = io_in_valid && w_ready;
    w_last      = (w_count_inc == r_len);
    // Narrowing to ADDR_W bits makes base+count wrap modulo the RAM depth.
    w_addr      = r_base + r_count[ADDR_W-1:0];
  end

  // Transfer sequencing: latch parameters on start, count accepted beats,
  // finish on the last beat or on abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_len        <= '0;
      r_count      <= '0;
      r_abort_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_start) begin
            r_base       <= io_baseAddr;
            r_len        <= io_len;
            r_count      <= '0;
            r_abort_seen <= 1'b0;
            r_state      <= (io_len == C_ZERO) ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (io_abort) begin
            r_abort_seen <= 1'b1;
            r_state      <= ST_FIN;
          end else if (w_accept) begin
            r_count <= w_count_inc;
            if (w_last) begin
              r_state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM write port: one registered write per accepted beat; address and data
  // hold their last value when no beat is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ena  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_ena <= w_accept;
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_beat.data;
      end
    end
  end

  // Completion pulse issued the cycle after FIN, so it trails the final
  // RAM write by one cycle; aborted qualifies the same pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= (r_state == ST_FIN);
      r_aborted <= (r_state == ST_FIN) && r_abort_seen;
    end
  end

  assign io_in_ready  = w_ready;
  assign io_wrEna     = r_wr_ena;
  assign io_wrAddr    = r_wr_addr;
  assign io_wrData    = r_wr_data;
  assign io_busy      = (r_state == ST_RUN);
  assign io_done      = r_done;
  assign io_aborted   = r_aborted;
  assign io_wordCount = r_count;

endmodule : mem_stream_writer

`default_nettype wire

// File: tb/tb_mem_stream_writer.sv
// ============================================================================
//  Module     : tb_mem_stream_writer
//  Description: Directed self-checking bench for mem_stream_writer with a
//               write scoreboard.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stream_writer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_start = 1'b0;
  logic [ADDR_W-1:0] io_baseAddr = '0;
  logic [ADDR_W:0]   io_len = '0;
  logic              io_abort = 1'b0;
  logic              io_in_valid = 1'b0;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_in_data = '0;
  logic              io_wrEna;
  logic [ADDR_W-1:0] io_wrAddr;
  logic [DATA_W-1:0] io_wrData;
  logic              io_busy;
  logic              io_done;
  logic              io_aborted;
  logic [ADDR_W:0]   io_wordCount;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int done_seen = 0;
  wr_t exp_q[$];

  mem_stream_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_baseAddr  (io_baseAddr),
    .io_len       (io_len),
    .io_abort     (io_abort),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_wrEna     (io_wrEna),
    .io_wrAddr    (io_wrAddr),
    .io_wrData    (io_wrData),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_aborted   (io_aborted),
    .io_wordCount (io_wordCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    io_start    = 1'b1;
    io_baseAddr = base;
    io_len      = len;
    cyc();
    io_start    = 1'b0;
  endtask

  // Waits for io_done within a cycle budget; a missed pulse counts as a failure.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (io_done !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check(tag, {31'd0, io_done}, 32'd1);
  endtask

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(posedge clock) begin
    #2;
    if (io_done === 1'b1) done_seen++;
    if (io_wrEna === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(io_wrAddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(io_wrAddr), 32'(e.addr));
        check("wr_data", io_wrData, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    int d0;

    // Power-on reset values.
    repeat (2) cyc();
    reset = 1'b0;
    check("rst_ready", {31'd0, io_in_ready}, 32'd0);
    check("rst_wrEna", {31'd0, io_wrEna}, 32'd0);
    check("rst_busy", {31'd0, io_busy}, 32'd0);
    check("rst_done", {31'd0, io_done}, 32'd0);
    check("rst_wrAddr", 32'(io_wrAddr), 32'd0);
    check("rst_wordCount", 32'(io_wordCount), 32'd0);

    // T2: base 0, len 4, valid every cycle.
    io_in_valid = 1'b1;
    io_in_data  = 32'hA0;
    start(10'd0, 11'd4);
    check("t2_busy", {31'd0, io_busy}, 32'd1);
    check("t2_ready", {31'd0, io_in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      io_in_data = 32'hA0 + 32'(k);
      push(10'(k), 32'hA0 + 32'(k));
      cyc();
    end
    io_in_valid = 1'b0;
    check("t2_fin_busy", {31'd0, io_busy}, 32'd0);
    check("t2_fin_wrEna_last", {31'd0, io_wrEna}, 32'd1);
    check("t2_done_not_yet", {31'd0, io_done}, 32'd0);
    cyc();
    check("t2_done", {31'd0, io_done}, 32'd1);
    check("t2_aborted", {31'd0, io_aborted}, 32'd0);
    check("t2_wordCount", 32'(io_wordCount), 32'd4);
    check("t2_hold_addr", 32'(io_wrAddr), 32'd3);
    check("t2_hold_data", io_wrData, 32'hA3);
    cyc();
    check("t2_done_one_cycle", {31'd0, io_done}, 32'd0);
    check("t2_wrEna_low", {31'd0, io_wrEna}, 32'd0);

    // T3: bubbles in valid, base 5, len 2.
    w0 = writes_seen;
    start(10'd5, 11'd2);
    io_in_valid = 1'b1; io_in_data = 32'hB0; push(10'd5, 32'hB0); cyc();
    io_in_valid = 1'b0; io_in_data = 32'hBB; cyc();
    check("t3_no_write_after_bubble", {31'd0, io_wrEna}, 32'd0);
    io_in_valid = 1'b1; io_in_data = 32'hB1; push(10'd6, 32'hB1); cyc();
    io_in_valid = 1'b0; cyc();
    wait_done("t3_done", 5);
    check("t3_wordCount", 32'(io_wordCount), 32'd2);
    check("t3_write_count", 32'(writes_seen - w0), 32'd2);
    cyc();

    // T4: address wrap past the top of the RAM.
    start(10'h3FE, 11'd4);
    io_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      io_in_data = 32'hC0 + 32'(k);
      push(10'h3FE + 10'(k), 32'hC0 + 32'(k));
      cyc();
    end
    io_in_valid = 1'b0;
    wait_done("t4_done", 5);
    check("t4_wordCount", 32'(io_wordCount), 32'd4);
    cyc();

    // T5: zero-length transfer, then a start during RUN that must be ignored.
    w0 = writes_seen;
    start(10'h100, 11'd0);
    check("t5_len0_busy", {31'd0, io_busy}, 32'd0);
    cyc();
    check("t5_len0_done", {31'd0, io_done}, 32'd1);
    check("t5_len0_wordCount", 32'(io_wordCount), 32'd0);
    check("t5_len0_writes", 32'(writes_seen - w0), 32'd0);
    cyc();
    start(10'h010, 11'd2);
    io_start = 1'b1; io_baseAddr = 10'h200; io_len = 11'd5;
    io_in_valid = 1'b1; io_in_data = 32'hD0; push(10'h010, 32'hD0);
    cyc();
    io_start = 1'b0;
    io_in_data = 32'hD1; push(10'h011, 32'hD1);
    cyc();
    io_in_valid = 1'b0;
    wait_done("t5_run_done", 5);
    check("t5_run_wordCount", 32'(io_wordCount), 32'd2);
    cyc();

    // T6: abort after two of eight beats.
    w0 = writes_seen;
    d0 = done_seen;
    start(10'h020, 11'd8);
    io_in_valid = 1'b1;
    io_in_data = 32'hE0; push(10'h020, 32'hE0); cyc();
    io_in_data = 32'hE1; push(10'h021, 32'hE1); cyc();
    io_in_data = 32'hE2; io_abort = 1'b1;
    #1;
    check("t6_ready_masked", {31'd0, io_in_ready}, 32'd0);
    cyc();
    io_abort = 1'b0; io_in_valid = 1'b0;
    wait_done("t6_done", 5);
    check("t6_aborted", {31'd0, io_aborted}, 32'd1);
    check("t6_wordCount", 32'(io_wordCount), 32'd2);
    cyc();
    check("t6_write_count", 32'(writes_seen - w0), 32'd2);
    check("t6_one_done", 32'(done_seen - d0), 32'd1);
    start(10'h030, 11'd1);
    io_in_valid = 1'b1; io_in_data = 32'hF0; push(10'h030, 32'hF0); cyc();
    io_in_valid = 1'b0;
    wait_done("t6_next_done", 5);
    check("t6_next_aborted", {31'd0, io_aborted}, 32'd0);
    check("t6_next_wordCount", 32'(io_wordCount), 32'd1);
    cyc();

    // T1: reset held two cycles in the middle of a transfer.
    d0 = done_seen;
    start(10'h040, 11'd4);
    check("t1_busy_before", {31'd0, io_busy}, 32'd1);
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    check("t1_busy", {31'd0, io_busy}, 32'd0);
    check("t1_ready", {31'd0, io_in_ready}, 32'd0);
    check("t1_wrAddr", 32'(io_wrAddr), 32'd0);
    check("t1_wrData", io_wrData, 32'd0);
    check("t1_wordCount", 32'(io_wordCount), 32'd0);
    repeat (4) cyc();
    check("t1_no_done", 32'(done_seen - d0), 32'd0);
    // A fresh start after reset must behave normally (writer back in IDLE).
    start(10'h050, 11'd1);
    io_in_valid = 1'b1; io_in_data = 32'h55; push(10'h050, 32'h55); cyc();
    io_in_valid = 1'b0;
    wait_done("t1_restart_done", 5);
    cyc();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_stream_writer

`default_nettype wire
